// File: rtl/demosaic_cross_window_pkg.sv
// ============================================================================
// Module : demosaic_pkg
// Brief  : Shared types for the demosaic cross-window extractor. Defining
//          XWIN_ZERO_PAD_EN replaces border mirroring with zero padding.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package demosaic_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH1 = 2'd1,
        ST_FLUSH2 = 2'd2
    } state_t;

    // Position of the centre relative to a frame edge along one axis
    typedef enum logic [2:0] {
        BRD_NONE  = 3'd0,
        BRD_NEAR0 = 3'd1,
        BRD_NEAR1 = 3'd2,
        BRD_FAR1  = 3'd3,
        BRD_FAR0  = 3'd4
    } brd_t;

    localparam int TAP_M2 = 0;
    localparam int TAP_M1 = 1;
    localparam int TAP_C  = 2;
    localparam int TAP_P1 = 3;
    localparam int TAP_P2 = 4;
    localparam int TAPS   = 5;

`ifdef XWIN_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

endpackage

`default_nettype wire

// File: rtl/demosaic_cross_window_if.sv
// ============================================================================
// Module : demosaic_cross_window_if
// Brief  : Column-tap input and cross-tap output bundle of the extractor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface demosaic_cross_window_if #(
    parameter int PIX_W = 8
);
    logic             IN_VALID;
    logic [PIX_W-1:0] DATA1, DATA2, DATA3, DATA4, DATA5;
    logic [PIX_W-1:0] UU, UP, MID, DN, DD;
    logic [PIX_W-1:0] LL, LF, RT, RR;
    logic             O_EN, O_SOF, O_EOL, OVERRUN;

    modport master (
        output IN_VALID, DATA1, DATA2, DATA3, DATA4, DATA5,
        input  UU, UP, MID, DN, DD, LL, LF, RT, RR,
        input  O_EN, O_SOF, O_EOL, OVERRUN
    );

    modport slave (
        input  IN_VALID, DATA1, DATA2, DATA3, DATA4, DATA5,
        output UU, UP, MID, DN, DD, LL, LF, RT, RR,
        output O_EN, O_SOF, O_EOL, OVERRUN
    );
endinterface

`default_nettype wire

// File: rtl/demosaic_cross_window_hmirror.sv
// ============================================================================
// Module : xwin_hmirror_shift
// Brief  : Centre-row 5-tap window (4 registers + live input) with edge mux.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module xwin_hmirror_shift
    import demosaic_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic [PIX_W-1:0] din,
    input  brd_t             brd,
    output logic [PIX_W-1:0] ll,
    output logic [PIX_W-1:0] lf,
    output logic [PIX_W-1:0] mid,
    output logic [PIX_W-1:0] rt,
    output logic [PIX_W-1:0] rr
);

    logic [PIX_W-1:0] r_sr  [TAPS-1];
    logic [PIX_W-1:0] w_win [TAPS];

    // Flush cycles shift a dummy in so the window stays aligned on c-2..c+2
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TAPS-1; i++) r_sr[i] <= '0;
        end else if (shift_en) begin
            r_sr[0] <= din;
            for (int i = 1; i < TAPS-1; i++) r_sr[i] <= r_sr[i-1];
        end
    end

    always_comb begin
        w_win[TAP_P2] = din;
        w_win[TAP_P1] = r_sr[0];
        w_win[TAP_C]  = r_sr[1];
        w_win[TAP_M1] = r_sr[2];
        w_win[TAP_M2] = r_sr[3];
    end

    always_comb begin
        ll  = w_win[TAP_M2];
        lf  = w_win[TAP_M1];
        mid = w_win[TAP_C];
        rt  = w_win[TAP_P1];
        rr  = w_win[TAP_P2];
        case (brd)
            BRD_NEAR0: begin
                lf = ZERO_PAD ? '0 : w_win[TAP_P1];
                ll = ZERO_PAD ? '0 : w_win[TAP_P2];
            end
            BRD_NEAR1: ll = ZERO_PAD ? '0 : w_win[TAP_C];
            BRD_FAR1:  rr = ZERO_PAD ? '0 : w_win[TAP_C];
            BRD_FAR0: begin
                rt = ZERO_PAD ? '0 : w_win[TAP_M1];
                rr = ZERO_PAD ? '0 : w_win[TAP_M2];
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/demosaic_cross_window.sv
// ============================================================================
// Module : demosaic_cross_window
// Brief  : 5x5 cross-neighbourhood extractor with Bayer-preserving borders.
//          XWIN_ZERO_PAD_EN selects zero padding instead of mirroring.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module demosaic_cross_window
    import demosaic_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int COLS  = 512,
    parameter int LINES = 768,
    parameter int CNT_W = 11
) (
    input  logic                     INCLK,
    input  logic                     RST,
    demosaic_cross_window_if.slave   bus
);

    localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO       = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_THREE     = CNT_W'(3);
    localparam logic [CNT_W-1:0] C_COL_LAST  = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] C_LINE_LAST = CNT_W'(LINES - 1);
    localparam logic [CNT_W-1:0] C_LINE_PEN  = CNT_W'(LINES - 2);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_col, r_line;
    logic             w_accept, w_flush, w_shift, w_emit;
    brd_t             w_hbrd, w_vbrd;

    // Off-centre rows, index 0..3 = DATA1, DATA2, DATA4, DATA5
    logic [PIX_W-1:0] w_rows [4];
    logic [PIX_W-1:0] r_d1   [4];
    logic [PIX_W-1:0] r_d2   [4];

    logic [PIX_W-1:0] w_ll, w_lf, w_mid, w_rt, w_rr;
    logic [PIX_W-1:0] w_uu, w_up, w_dn, w_dd;
    logic [PIX_W-1:0] r_uu, r_up, r_mid, r_dn, r_dd, r_ll, r_lf, r_rt, r_rr;
    logic             r_en, r_sof, r_eol, r_overrun;

    assign w_rows[0] = bus.DATA1;
    assign w_rows[1] = bus.DATA2;
    assign w_rows[2] = bus.DATA4;
    assign w_rows[3] = bus.DATA5;

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_flush  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_accept = bus.IN_VALID;
                if (bus.IN_VALID && (r_col == C_COL_LAST)) w_next = ST_FLUSH1;
            end
            ST_FLUSH1: begin
                w_flush = 1'b1;
                w_next  = ST_FLUSH2;
            end
            ST_FLUSH2: begin
                w_flush = 1'b1;
                w_next  = ST_RUN;
            end
            default: w_next = ST_RUN;
        endcase
        w_shift = w_accept | w_flush;
        w_emit  = (w_accept && (r_col >= C_TWO)) || w_flush;
    end

    always_comb begin
        w_hbrd = BRD_NONE;
        if (r_state == ST_FLUSH1)      w_hbrd = BRD_FAR1;
        else if (r_state == ST_FLUSH2) w_hbrd = BRD_FAR0;
        else if (r_col == C_TWO)       w_hbrd = BRD_NEAR0;
        else if (r_col == C_THREE)     w_hbrd = BRD_NEAR1;

        w_vbrd = BRD_NONE;
        if (r_line == '0)               w_vbrd = BRD_NEAR0;
        else if (r_line == C_ONE)       w_vbrd = BRD_NEAR1;
        else if (r_line == C_LINE_PEN)  w_vbrd = BRD_FAR1;
        else if (r_line == C_LINE_LAST) w_vbrd = BRD_FAR0;
    end

    xwin_hmirror_shift #(
        .PIX_W (PIX_W)
    ) u_hmirror (
        .clk      (INCLK),
        .rst      (RST),
        .shift_en (w_shift),
        .din      (bus.DATA3),
        .brd      (w_hbrd),
        .ll       (w_ll),
        .lf       (w_lf),
        .mid      (w_mid),
        .rt       (w_rt),
        .rr       (w_rr)
    );

    always_comb begin
        w_uu = r_d2[0];
        w_up = r_d2[1];
        w_dn = r_d2[2];
        w_dd = r_d2[3];
        case (w_vbrd)
            BRD_NEAR0: begin
                w_up = ZERO_PAD ? '0 : r_d2[2];
                w_uu = ZERO_PAD ? '0 : r_d2[3];
            end
            BRD_NEAR1: w_uu = ZERO_PAD ? '0 : w_mid;
            BRD_FAR1:  w_dd = ZERO_PAD ? '0 : w_mid;
            BRD_FAR0: begin
                w_dn = ZERO_PAD ? '0 : r_d2[1];
                w_dd = ZERO_PAD ? '0 : r_d2[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge INCLK) begin
        if (RST) begin
            r_state   <= ST_RUN;
            r_col     <= '0;
            r_line    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_d1[i] <= '0;
                r_d2[i] <= '0;
            end
            {r_uu, r_up, r_mid, r_dn, r_dd} <= '0;
            {r_ll, r_lf, r_rt, r_rr}        <= '0;
            {r_en, r_sof, r_eol, r_overrun} <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept && (r_col != C_COL_LAST)) r_col <= r_col + C_ONE;
            if (r_state == ST_FLUSH2) begin
                r_col  <= '0;
                r_line <= (r_line == C_LINE_LAST) ? '0 : r_line + C_ONE;
            end
            if (w_shift) begin
                for (int i = 0; i < 4; i++) begin
                    r_d1[i] <= w_rows[i];
                    r_d2[i] <= r_d1[i];
                end
            end
            r_en  <= w_emit;
            r_sof <= w_emit && w_accept && (w_hbrd == BRD_NEAR0) && (r_line == '0);
            r_eol <= (r_state == ST_FLUSH2);
            if (w_flush && bus.IN_VALID) r_overrun <= 1'b1;
            if (w_emit) begin
                r_uu  <= w_uu;
                r_up  <= w_up;
                r_mid <= w_mid;
                r_dn  <= w_dn;
                r_dd  <= w_dd;
                r_ll  <= w_ll;
                r_lf  <= w_lf;
                r_rt  <= w_rt;
                r_rr  <= w_rr;
            end
        end
    end

    assign bus.UU      = r_uu;
    assign bus.UP      = r_up;
    assign bus.MID     = r_mid;
    assign bus.DN      = r_dn;
    assign bus.DD      = r_dd;
    assign bus.LL      = r_ll;
    assign bus.LF      = r_lf;
    assign bus.RT      = r_rt;
    assign bus.RR      = r_rr;
    assign bus.O_EN    = r_en;
    assign bus.O_SOF   = r_sof;
    assign bus.O_EOL   = r_eol;
    assign bus.OVERRUN = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_demosaic_cross_window.sv
// ============================================================================
// Module : tb_demosaic_cross_window
// Brief  : Directed bench for demosaic_cross_window (8x6 frame, pixel=16y+x).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_demosaic_cross_window;

    localparam int PW = 8;
    localparam int NC = 8;
    localparam int NL = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    demosaic_cross_window_if #(.PIX_W(PW)) xif();

    demosaic_cross_window #(
        .PIX_W (PW),
        .COLS  (NC),
        .LINES (NL),
        .CNT_W (4)
    ) dut (
        .INCLK (clk),
        .RST   (rst),
        .bus   (xif)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [7:0] pix(input int x, input int y);
        return 8'(16 * y + x);
    endfunction

    // What the line buffer presents; rows outside the frame carry junk
    function automatic logic [7:0] row_in(input int x, input int y);
        if (y < 0 || y >= NL) return 8'hEE;
        return pix(x, y);
    endfunction

    function automatic int mir(input int i, input int n);
        if (i < 0)  return -i;
        if (i >= n) return 2 * (n - 1) - i;
        return i;
    endfunction

    function automatic logic [7:0] mtap(input int x, input int y);
`ifdef XWIN_ZERO_PAD_EN
        if (x < 0 || x >= NC || y < 0 || y >= NL) return 8'h00;
`endif
        return pix(mir(x, NC), mir(y, NL));
    endfunction

    function automatic logic [71:0] model(input int c, input int y);
        return {mtap(c, y-2), mtap(c, y-1), mtap(c, y), mtap(c, y+1), mtap(c, y+2),
                mtap(c-2, y), mtap(c-1, y), mtap(c+1, y), mtap(c+2, y)};
    endfunction

    function automatic logic [71:0] pk(input int uu, input int up, input int mid,
                                       input int dn, input int dd, input int ll,
                                       input int lf, input int rt, input int rr);
        return {8'(uu), 8'(up), 8'(mid), 8'(dn), 8'(dd), 8'(ll), 8'(lf), 8'(rt), 8'(rr)};
    endfunction

    function automatic logic [71:0] got_cross();
        return {xif.UU, xif.UP, xif.MID, xif.DN, xif.DD, xif.LL, xif.LF, xif.RT, xif.RR};
    endfunction

    // Emission monitor: every O_EN cycle is compared with the mirror model
    int          mc = 0, my = 0;
    int          n_en = 0, n_sof = 0, n_eol = 0;
    logic [71:0] seen     [NC][NL];
    logic        seen_sof [NC][NL];

    always @(negedge clk) begin
        if (rst) begin
            mc = 0;
            my = 0;
        end else if (xif.O_EN) begin
            n_en++;
            if (xif.O_SOF) n_sof++;
            if (xif.O_EOL) n_eol++;
            check($sformatf("cross(%0d,%0d)", mc, my),
                  {got_cross(), xif.O_SOF, xif.O_EOL},
                  {model(mc, my), (mc == 0 && my == 0), (mc == NC - 1)});
            seen[mc][my]     = got_cross();
            seen_sof[mc][my] = xif.O_SOF;
            if (mc == NC - 1) begin
                mc = 0;
                my = (my == NL - 1) ? 0 : my + 1;
            end else begin
                mc++;
            end
        end
    end

    task automatic drive(input logic v, input int x, input int y);
        @(negedge clk);
        xif.IN_VALID = v;
        xif.DATA1    = row_in(x, y - 2);
        xif.DATA2    = row_in(x, y - 1);
        xif.DATA3    = row_in(x, y);
        xif.DATA4    = row_in(x, y + 1);
        xif.DATA5    = row_in(x, y + 2);
    endtask

    // mode 0: continuous; 1: valid toggled; 2: valid held through the flush gap
    task automatic send_line(input int y, input int mode, input int ncols);
        for (int x = 0; x < ncols; x++) begin
            drive(1'b1, x, y);
            if (mode == 1 && x < ncols - 1) drive(1'b0, x, y);
        end
        if (ncols == NC) begin
            if (mode == 2) begin
                drive(1'b1, 99, y);
                @(posedge clk);
                #1 check("overrun_set", xif.OVERRUN, 1);
                drive(1'b1, 98, y);
            end else begin
                drive(1'b0, 0, 0);
                drive(1'b0, 0, 0);
            end
        end
    endtask

    logic [71:0] c00, c75, c32;
    int          e0, s0, l0;

    initial begin
`ifdef XWIN_ZERO_PAD_EN
        c00 = pk(0, 0, 0, 16, 32, 0, 0, 1, 2);
        c75 = pk(55, 71, 87, 0, 0, 85, 86, 0, 0);
`else
        c00 = pk(32, 16, 0, 16, 32, 2, 1, 1, 2);
        c75 = pk(55, 71, 87, 71, 55, 85, 86, 86, 85);
`endif
        c32 = pk(3, 19, 35, 51, 67, 33, 34, 36, 37);

        xif.IN_VALID = 1'b0;
        xif.DATA1 = '0; xif.DATA2 = '0; xif.DATA3 = '0; xif.DATA4 = '0; xif.DATA5 = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_state",
              {got_cross(), xif.O_EN, xif.O_SOF, xif.O_EOL, xif.OVERRUN}, 0);
        rst = 1'b0;

        // Frame 1: plain continuous stream
        e0 = n_en; s0 = n_sof; l0 = n_eol;
        for (int y = 0; y < NL; y++) send_line(y, 0, NC);
        repeat (3) drive(1'b0, 0, 0);
        check("frame_en_count",  n_en - e0, 48);
        check("frame_sof_count", n_sof - s0, 1);
        check("frame_eol_count", n_eol - l0, 6);
        check("centre_0_0",      seen[0][0], c00);
        check("sof_at_0_0",      seen_sof[0][0], 1);
        check("centre_7_5",      seen[7][5], c75);
        check("no_overrun",      xif.OVERRUN, 0);

        // Frame 2: toggled valid on line 2, overrun on line 3
        send_line(0, 0, NC);
        send_line(1, 0, NC);
        send_line(2, 1, NC);
        check("centre_3_2_toggled", seen[3][2], c32);
        send_line(3, 2, NC);
        send_line(4, 0, NC);
        send_line(5, 0, NC);
        check("overrun_sticky", xif.OVERRUN, 1);

        // Frame 3: reset in the middle of line 2
        send_line(0, 0, NC);
        send_line(1, 0, NC);
        send_line(2, 0, 4);
        @(negedge clk);
        rst = 1'b1;
        xif.IN_VALID = 1'b0;
        @(posedge clk);
        #1 check("reset_midline",
                 {got_cross(), xif.O_EN, xif.O_SOF, xif.O_EOL, xif.OVERRUN}, 0);
        @(negedge clk);
        rst = 1'b0;

        e0 = n_en; s0 = n_sof;
        send_line(0, 0, NC);
        send_line(1, 0, NC);
        repeat (2) drive(1'b0, 0, 0);
        check("restart_en_count",  n_en - e0, 16);
        check("restart_sof_count", n_sof - s0, 1);
        check("restart_centre_0_0", seen[0][0], c00);
        check("restart_sof_0_0",    seen_sof[0][0], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
